// File: rtl/ppu_oam_dma.sv
// ---------------------------------------------------------------------------
// ppu_oam_dma
//
// Sprite DMA engine sitting behind the CPU write port $4014. A CPU write of
// page P to DMA_REG_ADDR copies CPU addresses P00..PFF into OAM. Each byte is
// one bus read of {P, index} followed by one bus write to OAM_DATA_ADDR. The
// CPU core is stalled for the whole transfer.
//
// Ports:
//   i_cpu_clk    CPU clock; every flop is on its rising edge
//   i_cpu_rst    synchronous, active-high reset
//   i_bus_addr   CPU bus address, snooped for the trigger write
//   i_bus_wn     CPU bus write-not (0 = write)
//   i_bus_wdata  CPU bus write data (page number on a trigger)
//   o_spr_req    bus request to the sprite arbiter
//   i_spr_gnt    bus grant from the arbiter
//   o_spr_addr   master address
//   o_spr_wn     master write-not
//   o_spr_wdata  master write data (read data passed through during WRITE)
//   i_spr_rdata  master read data, valid the cycle after the read address
//   o_cpu_stall  halts the CPU core while high
//   o_dma_done   one-cycle pulse after the last OAM byte is written
//
// Request/grant handshake: o_spr_req is held high from the first waiting
// cycle through the final write. A bus cycle (dummy, read or write) only
// takes effect in a cycle where i_spr_gnt is high; in a cycle with the
// grant low the FSM and all registered outputs hold, so that same bus cycle
// is presented again once the grant returns.
// ---------------------------------------------------------------------------
module ppu_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        i_cpu_clk,
    input  logic        i_cpu_rst,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    output logic        o_spr_req,
    input  logic        i_spr_gnt,
    output logic [15:0] o_spr_addr,
    output logic        o_spr_wn,
    output logic [7:0]  o_spr_wdata,
    input  logic [7:0]  i_spr_rdata,
    output logic        o_cpu_stall,
    output logic        o_dma_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_GNT = 3'd1,
        S_ALIGN    = 3'd2,
        S_ALIGN2   = 3'd3,
        S_READ     = 3'd4,
        S_WRITE    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t      state_q;
    logic [7:0]  page_q;
    logic [7:0]  index_q;
    logic [7:0]  index_d;
    logic        parity_q;
    logic        parity_d;
    logic        req_q;
    logic [15:0] addr_q;
    logic        wn_q;
    logic        stall_q;
    logic        done_q;
    logic        cpu_trig;

    assign cpu_trig = (i_bus_addr == DMA_REG_ADDR) && !i_bus_wn;
    assign index_d  = index_q + 8'd1;

    // Free-running odd/even cycle marker; it decides whether ALIGN needs a
    // second dummy cycle, reproducing the 513/514-cycle console timing.
    assign parity_d = ~parity_q;

    always_ff @(posedge i_cpu_clk) begin
        if (i_cpu_rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    // Outputs are registered alongside the state: each transition loads the
    // bus values that belong to the state being entered.
    always_ff @(posedge i_cpu_clk) begin
        if (i_cpu_rst) begin
            state_q <= S_IDLE;
            page_q  <= 8'h00;
            index_q <= 8'h00;
            req_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wn_q    <= 1'b1;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_trig) begin
                        page_q  <= i_bus_wdata;
                        req_q   <= 1'b1;
                        stall_q <= 1'b1;
                        state_q <= S_WAIT_GNT;
                    end
                end
                S_WAIT_GNT: begin
                    if (i_spr_gnt) begin
                        state_q <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (i_spr_gnt) begin
                        if (parity_q) begin
                            state_q <= S_ALIGN2;
                        end else begin
                            addr_q  <= {page_q, index_q};
                            wn_q    <= 1'b1;
                            state_q <= S_READ;
                        end
                    end
                end
                S_ALIGN2: begin
                    if (i_spr_gnt) begin
                        addr_q  <= {page_q, index_q};
                        wn_q    <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (i_spr_gnt) begin
                        addr_q  <= OAM_DATA_ADDR;
                        wn_q    <= 1'b0;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (i_spr_gnt) begin
                        wn_q <= 1'b1;
                        if (index_q == 8'hFF) begin
                            req_q   <= 1'b0;
                            stall_q <= 1'b0;
                            done_q  <= 1'b1;
                            index_q <= 8'h00;
                            addr_q  <= 16'h0000;
                            state_q <= S_DONE;
                        end else begin
                            index_q <= index_d;
                            addr_q  <= {page_q, index_d};
                            state_q <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    index_q <= 8'h00;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_spr_req   = req_q;
    assign o_spr_addr  = addr_q;
    assign o_spr_wn    = wn_q;
    assign o_cpu_stall = stall_q;
    assign o_dma_done  = done_q;

    // Read data arrives the cycle after the read address, which is exactly
    // the WRITE cycle, so it is forwarded combinationally.
    assign o_spr_wdata = (state_q == S_WRITE) ? i_spr_rdata : 8'h00;

endmodule

// File: tb/tb_ppu_oam_dma.sv
module tb_ppu_oam_dma;

  logic        clk;
  logic        rst;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        spr_req;
  logic        spr_gnt;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [7:0]  spr_rdata;
  logic        cpu_stall;
  logic        dma_done;

  ppu_oam_dma dut (
    .i_cpu_clk   (clk),
    .i_cpu_rst   (rst),
    .i_bus_addr  (bus_addr),
    .i_bus_wn    (bus_wn),
    .i_bus_wdata (bus_wdata),
    .o_spr_req   (spr_req),
    .i_spr_gnt   (spr_gnt),
    .o_spr_addr  (spr_addr),
    .o_spr_wn    (spr_wn),
    .o_spr_wdata (spr_wdata),
    .i_spr_rdata (spr_rdata),
    .o_cpu_stall (cpu_stall),
    .o_dma_done  (dma_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int done_count = 0;

  logic [7:0]  mem [65536];
  logic [7:0]  exp_q[$];
  logic [15:0] exp_rd_q[$];
  logic [7:0]  cur_page = 8'h00;
  logic        tb_par = 1'b0;
  logic [7:0]  rdata_next = 8'h00;

  // monitor state
  logic        prev_rst = 1'b1;
  logic        prev_stall = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  logic        prev_wn = 1'b1;
  logic        par_align = 1'b0;
  logic        last_was_read = 1'b0;
  logic        first_rd_done = 1'b0;
  logic [7:0]  last_rd_idx = 8'h00;
  int          stall_idx = 0;
  int          gnt_idx = -1;
  int          ahits = 0;
  int          low_cnt = 0;
  int          rd_count = 0;
  int          wr_count = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Odd/even cycle reference: cleared by reset, flips on every other edge.
  always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;

  // Bus memory: a read granted in one cycle returns its data the next cycle.
  always @(negedge clk) begin
    if (spr_gnt && spr_req && spr_wn) rdata_next = mem[spr_addr];
    else rdata_next = spr_rdata;
  end
  always @(posedge clk) begin
    #1;
    spr_rdata = rdata_next;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (prev_rst) begin
      exp_q.delete();
      exp_rd_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (cpu_stall && !prev_stall) begin
        stall_idx = 0; gnt_idx = -1; ahits = 0; low_cnt = 0;
        rd_count = 0; wr_count = 0; last_was_read = 1'b0; first_rd_done = 1'b0;
      end else if (cpu_stall) begin
        stall_idx++;
      end

      if (cpu_stall) begin
        check_eq("req_with_stall", spr_req, 1'b1);
        if (prev_stall && !prev_gnt) begin
          check_eq("freeze_addr", spr_addr, prev_addr);
          check_eq("freeze_wn", spr_wn, prev_wn);
        end
      end

      // bus transactions
      if (spr_gnt && spr_req && spr_wn && spr_addr[15:8] == cur_page) begin
        check_eq("read_queue_nonempty", exp_rd_q.size() != 0, 1'b1);
        if (exp_rd_q.size() != 0) check_eq("read_addr", spr_addr, exp_rd_q.pop_front());
        check_eq("read_after_write", last_was_read, 1'b0);
        if (!first_rd_done) begin
          check_eq("align_cycles", ahits, 1 + par_align);
          first_rd_done = 1'b1;
        end
        last_was_read = 1'b1;
        last_rd_idx = spr_addr[7:0];
        rd_count++;
      end else if (spr_gnt && spr_req && !spr_wn) begin
        check_eq("write_addr", spr_addr, 16'h2004);
        check_eq("write_queue_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check_eq("write_data", spr_wdata, exp_q.pop_front());
        check_eq("write_after_read", last_was_read, 1'b1);
        last_was_read = 1'b0;
        wr_count++;
      end else if (cpu_stall && gnt_idx >= 0 && stall_idx > gnt_idx) begin
        // granted cycles before the first read are the alignment dummies
        if (!spr_gnt) low_cnt++;
        else if (!first_rd_done) begin
          if (ahits == 0) par_align = tb_par;
          ahits++;
        end
      end else if (cpu_stall && gnt_idx >= 0 && stall_idx > gnt_idx && !spr_gnt) begin
        low_cnt++;
      end
      if (cpu_stall && gnt_idx >= 0 && stall_idx > gnt_idx && first_rd_done && !spr_gnt
          && !(spr_req && spr_wn && spr_addr[15:8] == cur_page))
        ;
      if (cpu_stall && gnt_idx < 0 && spr_gnt) gnt_idx = stall_idx;

      if (prev_stall && !cpu_stall) begin
        check_eq("done_at_end", dma_done, 1'b1);
        check_eq("stall_len", stall_idx + 1, gnt_idx + 2 + par_align + 512 + low_cnt);
        check_eq("write_count", wr_count, 256);
        check_eq("writes_left", exp_q.size(), 0);
      end
    end
    if (dma_done) done_count++;
    prev_rst = rst;
    prev_stall = cpu_stall;
    prev_gnt = spr_gnt;
    prev_addr = spr_addr;
    prev_wn = spr_wn;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus_addr = a; bus_wn = 1'b0; bus_wdata = d;
    tick();
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
  endtask

  task automatic push_expect(input logic [7:0] page);
    logic [15:0] a;
    cur_page = page;
    for (int i = 0; i < 256; i++) begin
      a = {page, 8'(i)};
      exp_rd_q.push_back(a);
      exp_q.push_back(mem[a]);
    end
    exp_done++;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_count;
    n = 0;
    while (done_count == start && n < budget) begin
      tick();
      n++;
    end
    check_eq("done_seen", done_count != start, 1'b1);
    repeat (3) tick();
  endtask

  task automatic wait_rd(input logic [7:0] idx, input int budget);
    int n;
    n = 0;
    while (!(rd_count > 0 && last_rd_idx == idx) && n < budget) begin
      tick();
      n++;
    end
    check_eq("read_reached", last_rd_idx, idx);
  endtask

  task automatic wait_par(input logic want);
    int n;
    n = 0;
    while (tb_par != want && n < 4) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, spr_req, 1'b0);
    check_eq({tag, "_addr"}, spr_addr, 16'h0000);
    check_eq({tag, "_wn"}, spr_wn, 1'b1);
    check_eq({tag, "_wdata"}, spr_wdata, 8'h00);
    check_eq({tag, "_stall"}, cpu_stall, 1'b0);
    check_eq({tag, "_done"}, dma_done, 1'b0);
  endtask

  task automatic run_page(input logic [7:0] page);
    push_expect(page);
    cpu_write(16'h4014, page);
    wait_done(1500);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] p;
    int start;
    int n;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    rst = 1'b1; spr_gnt = 1'b1; spr_rdata = 8'h00;
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) tick();

    // basic transfer of page 02 with the grant tied high
    run_page(8'h02);

    // both alignment parities
    for (int w = 0; w < 2; w++) begin
      p = 8'($urandom_range(1, 254));
      push_expect(p);
      wait_par(w[0]);
      cpu_write(16'h4014, p);
      wait_done(1500);
    end

    // grant withheld for 20 cycles, snoop writes, grant dropped at byte 40
    p = 8'($urandom_range(1, 254));
    push_expect(p);
    spr_gnt = 1'b0;
    cpu_write(16'h4014, p);
    for (int k = 0; k < 20; k++) begin
      if (k == 10) cpu_write(16'h4014, p ^ 8'h33);
      else tick();
      @(negedge clk);
      check_eq("wait_req", spr_req, 1'b1);
      check_eq("wait_stall", cpu_stall, 1'b1);
      check_eq("wait_no_read", rd_count, 0);
    end
    @(posedge clk); #1;
    spr_gnt = 1'b1;
    wait_rd(8'h40, 600);
    spr_gnt = 1'b0;
    repeat (5) tick();
    spr_gnt = 1'b1;
    wait_rd(8'h90, 600);
    cpu_write(16'h4014, p ^ 8'h55);
    wait_done(1500);

    // reset during byte 80 aborts the transfer
    p = 8'($urandom_range(1, 254));
    push_expect(p);
    cpu_write(16'h4014, p);
    wait_rd(8'h80, 600);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_done--;
    @(negedge clk);
    check_reset_outputs("abort");
    repeat (40) tick();
    check_eq("abort_no_done", done_count, exp_done);

    // page FF with a known pattern
    for (int i = 0; i < 256; i++) mem[{8'hFF, 8'(i)}] = 8'(i) ^ 8'h5A;
    run_page(8'hFF);

    // random pages under a randomly flickering grant
    for (int r = 0; r < 2; r++) begin
      p = 8'($urandom_range(1, 254));
      push_expect(p);
      cpu_write(16'h4014, p);
      start = done_count;
      n = 0;
      while (done_count == start && n < 4000) begin
        spr_gnt = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      spr_gnt = 1'b1;
      check_eq("rand_done_seen", done_count != start, 1'b1);
      repeat (3) tick();
    end

    check_eq("final_done_count", done_count, exp_done);
    check_eq("final_reads_left", exp_rd_q.size(), 0);
    check_eq("final_writes_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
